// File: rtl/alu_cmd_if.sv
// Host command/response and ALU operand/result signals of the ALU command driver.
// Handshake: a transfer happens on the rising edge where valid && ready; valid never waits on ready.
interface alu_cmd_if #(
    parameter int N = 4,
    parameter int M = 8,
    parameter int K = 8
);
    logic         i_cmd_valid;
    logic         o_cmd_ready;
    logic [N-1:0] i_cmd_op;
    logic [M-1:0] i_cmd_A;
    logic [M-1:0] i_cmd_B;
    logic [N-1:0] o_alu_op;
    logic [M-1:0] o_alu_A;
    logic [M-1:0] o_alu_B;
    logic [K-1:0] i_alu_result;
    logic [3:0]   i_alu_status;
    logic         o_rsp_valid;
    logic         i_rsp_ready;
    logic [K-1:0] o_rsp_result;
    logic [3:0]   o_rsp_status;
    logic         o_busy;
    logic [15:0]  o_issued_cnt;

    modport slave (
        input  i_cmd_valid, i_cmd_op, i_cmd_A, i_cmd_B,
        input  i_alu_result, i_alu_status, i_rsp_ready,
        output o_cmd_ready, o_alu_op, o_alu_A, o_alu_B,
        output o_rsp_valid, o_rsp_result, o_rsp_status, o_busy, o_issued_cnt
    );

    modport master (
        output i_cmd_valid, i_cmd_op, i_cmd_A, i_cmd_B,
        output i_alu_result, i_alu_status, i_rsp_ready,
        input  o_cmd_ready, o_alu_op, o_alu_A, o_alu_B,
        input  o_rsp_valid, o_rsp_result, o_rsp_status, o_busy, o_issued_cnt
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// Issues host commands to a fixed-latency ALU and returns results in order through
// a credit-protected response FIFO, so no ALU result can ever be dropped.
module alu_cmd_driver #(
    parameter int N     = 4,
    parameter int M     = 8,
    parameter int K     = 8,
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic      i_clk,
    input  logic      i_reset,
    alu_cmd_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 3;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [N-1:0]  r_alu_op;
    logic [M-1:0]  r_alu_A;
    logic [M-1:0]  r_alu_B;
    logic [LAT:0]  r_tag;
    logic [K-1:0]  r_mem_result [DEPTH];
    logic [3:0]    r_mem_status [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [15:0]   r_issued;

    logic [SW-1:0] w_inflight;
    logic [SW-1:0] w_occupancy;
    logic          w_ready;
    logic          w_accept;
    logic          w_capture;
    logic          w_rsp_valid;
    logic          w_pop;

    // Every tag bit is a result the FIFO has already promised a slot to.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i <= LAT; i++) begin
            w_inflight = w_inflight + SW'(r_tag[i]);
        end
    end

    assign w_occupancy = w_inflight + SW'(r_count);
    assign w_ready     = w_occupancy < SW'(DEPTH);
    assign w_accept    = bus.i_cmd_valid && w_ready;
    assign w_capture   = r_tag[LAT];
    assign w_rsp_valid = r_count != '0;
    assign w_pop       = w_rsp_valid && bus.i_rsp_ready;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_alu_op <= '0;
            r_alu_A  <= '0;
            r_alu_B  <= '0;
            r_tag    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_issued <= '0;
        end else begin
            if (w_accept) begin
                r_alu_op <= bus.i_cmd_op;
                r_alu_A  <= bus.i_cmd_A;
                r_alu_B  <= bus.i_cmd_B;
                r_issued <= r_issued + 16'd1;
            end
            r_tag <= {r_tag[LAT-1:0], w_accept};
            if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: r_count gates every read of it.
    always_ff @(posedge i_clk) begin
        if (w_capture) begin
            r_mem_result[r_wr_ptr] <= bus.i_alu_result;
            r_mem_status[r_wr_ptr] <= bus.i_alu_status;
        end
    end

    assign bus.o_cmd_ready  = w_ready;
    assign bus.o_alu_op     = r_alu_op;
    assign bus.o_alu_A      = r_alu_A;
    assign bus.o_alu_B      = r_alu_B;
    assign bus.o_rsp_valid  = w_rsp_valid;
    assign bus.o_rsp_result = w_rsp_valid ? r_mem_result[r_rd_ptr] : '0;
    assign bus.o_rsp_status = w_rsp_valid ? r_mem_status[r_rd_ptr] : '0;
    assign bus.o_busy       = (w_inflight != '0) || (r_count != '0);
    assign bus.o_issued_cnt = r_issued;

    a_credit_safe: assert property (@(posedge i_clk) disable iff (!i_reset)
        !(w_capture && (r_count == FULL) && !w_pop));
endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a registered LAT=1 ALU stub and an
// in-order response model that is checked on every falling edge.
module tb_alu_cmd_driver;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_if #(.N(4), .M(8), .K(8)) bus();

  alu_cmd_driver #(.N(4), .M(8), .K(8), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // ALU stub behaviour: {status, result}; status = {2'b00, carry, zero}
  function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] nb;
    logic [7:0] r;
    logic       c;
    nb = ~b;
    c  = 1'b0;
    s  = 9'd0;
    case (op)
      4'd0: r = a >> nb;
      4'd1: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
      4'd2: r = a ^ b;
      default: r = a & b;
    endcase
    return {2'b00, c, (r == 8'h00), r};
  endfunction

  always @(posedge clk) begin
    {bus.i_alu_status, bus.i_alu_result} <= alu_fn(bus.o_alu_op, bus.o_alu_A, bus.o_alu_B);
  end

  // ---------------- model ----------------
  logic [11:0] exp_q[$];
  int          acc_q[$];
  logic [7:0]  got_q[$];
  int          edge_n = 0;
  int          n_acc = 0;
  int          n_pop = 0;
  logic [3:0]  last_op = '0;
  logic [7:0]  last_a = '0;
  logic [7:0]  last_b = '0;

  function automatic logic model_valid();
    if (exp_q.size() == 0) return 1'b0;
    return (edge_n - acc_q[0]) >= LAT + 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge rst_n) begin
    exp_q.delete();
    acc_q.delete();
    edge_n  = 0;
    n_acc   = 0;
    n_pop   = 0;
    last_op = '0;
    last_a  = '0;
    last_b  = '0;
  end

  int occ_pre;
  always @(posedge clk) begin
    if (rst_n) begin
      occ_pre = n_acc - n_pop;
      if (bus.i_rsp_ready && model_valid()) begin
        got_q.push_back(bus.o_rsp_result);
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        n_pop++;
      end
      if (bus.i_cmd_valid && (occ_pre < DEPTH)) begin
        exp_q.push_back(alu_fn(bus.i_cmd_op, bus.i_cmd_A, bus.i_cmd_B));
        acc_q.push_back(edge_n + 1);
        last_op = bus.i_cmd_op;
        last_a  = bus.i_cmd_A;
        last_b  = bus.i_cmd_B;
        n_acc++;
      end
      edge_n++;
    end
  end

  int   occ_now;
  logic mv_now;
  always @(negedge clk) begin
    occ_now = n_acc - n_pop;
    mv_now  = model_valid();
    chk("cmd_ready", 32'(bus.o_cmd_ready), 32'(occ_now < DEPTH));
    chk("busy", 32'(bus.o_busy), 32'(occ_now != 0));
    chk("issued_cnt", 32'(bus.o_issued_cnt), 32'(16'(n_acc)));
    chk("alu_op", 32'(bus.o_alu_op), 32'(last_op));
    chk("alu_A", 32'(bus.o_alu_A), 32'(last_a));
    chk("alu_B", 32'(bus.o_alu_B), 32'(last_b));
    chk("rsp_valid", 32'(bus.o_rsp_valid), 32'(mv_now));
    chk("rsp_data", 32'({bus.o_rsp_status, bus.o_rsp_result}), 32'(mv_now ? exp_q[0] : 12'h000));
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic r;
    logic done;
    done = 1'b0;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_op    = op;
    bus.i_cmd_A     = a;
    bus.i_cmd_B     = b;
    for (int g = 0; g < 100; g++) begin
      r = bus.o_cmd_ready;
      @(negedge clk);
      if (r) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic drain();
    bus.i_rsp_ready = 1'b1;
    for (int g = 0; g < 60; g++) begin
      if (!bus.o_busy && exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_busy", 32'(bus.o_busy), 32'd0);
    chk("drain_model", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_got(input string name, input int n, input logic [7:0] lits [6]);
    chk(name, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got_q.size()) chk(name, 32'(got_q[i]), 32'(lits[i]));
    end
  endtask

  logic [7:0] lit_b2b  [6] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h00, 8'h00};
  logic [7:0] lit_bp   [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
  logic [7:0] lit_full [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_op    = '0;
    bus.i_cmd_A     = '0;
    bus.i_cmd_B     = '0;
    bus.i_rsp_ready = 1'b0;

    @(negedge clk);
    chk("reset_ready", 32'(bus.o_cmd_ready), 32'd1);
    chk("reset_valid", 32'(bus.o_rsp_valid), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // single command: 0xCC >> ~0xFE = 0x66
    send(4'd0, 8'hCC, 8'hFE);
    idle();
    chk("single_alu_A", 32'(bus.o_alu_A), 32'hCC);
    chk("single_valid_early", 32'(bus.o_rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    chk("single_valid", 32'(bus.o_rsp_valid), 32'd1);
    chk("single_result", 32'(bus.o_rsp_result), 32'h66);
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    chk("single_busy", 32'(bus.o_busy), 32'd0);
    chk("single_issued", 32'(bus.o_issued_cnt), 32'd1);
    bus.i_rsp_ready = 1'b0;

    // back-to-back with the response side always ready
    got_q.delete();
    bus.i_rsp_ready = 1'b1;
    send(4'd0, 8'h80, 8'hFE);
    send(4'd0, 8'h40, 8'hFE);
    send(4'd0, 8'h20, 8'hFE);
    send(4'd0, 8'h10, 8'hFE);
    idle();
    drain();
    check_got("b2b_rsp", 4, lit_b2b);
    chk("b2b_issued", 32'(bus.o_issued_cnt), 32'd5);

    // backpressure: only DEPTH commands fit until the host pops
    got_q.delete();
    bus.i_rsp_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(4'd1, 8'(i), 8'h10);
        idle();
      end
      begin
        repeat (8) @(negedge clk);
        chk("bp_ready", 32'(bus.o_cmd_ready), 32'd0);
        chk("bp_issued", 32'(bus.o_issued_cnt), 32'd9);
        chk("bp_head", 32'(bus.o_rsp_result), 32'h10);
        bus.i_rsp_ready = 1'b1;
      end
    join
    drain();
    check_got("bp_rsp", 6, lit_bp);
    chk("bp_issued_end", 32'(bus.o_issued_cnt), 32'd11);

    // full: 3 buffered + 1 in flight, pop exactly on the capture edge
    got_q.delete();
    bus.i_rsp_ready = 1'b0;
    send(4'd2, 8'h11, 8'h00);
    send(4'd2, 8'h22, 8'h00);
    send(4'd2, 8'h33, 8'h00);
    send(4'd2, 8'h44, 8'h00);
    idle();
    @(negedge clk);
    chk("full_ready", 32'(bus.o_cmd_ready), 32'd0);
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    bus.i_rsp_ready = 1'b0;
    chk("full_ready_after", 32'(bus.o_cmd_ready), 32'd1);
    chk("full_head", 32'(bus.o_rsp_result), 32'h22);
    @(negedge clk);
    chk("full_head_hold", 32'(bus.o_rsp_result), 32'h22);
    chk("full_ready_hold", 32'(bus.o_cmd_ready), 32'd1);
    drain();
    check_got("full_rsp", 4, lit_full);

    // async reset with 2 buffered and 1 in flight
    got_q.delete();
    bus.i_rsp_ready = 1'b0;
    send(4'd3, 8'hF0, 8'h3C);
    send(4'd3, 8'h0F, 8'hFF);
    send(4'd3, 8'hAA, 8'h55);
    idle();
    @(posedge clk);
    #2;
    chk("pre_rst_valid", 32'(bus.o_rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_alu_A", 32'(bus.o_alu_A), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    bus.i_rsp_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_issued", 32'(bus.o_issued_cnt), 32'd0);
    chk("post_rst_ready", 32'(bus.o_cmd_ready), 32'd1);
    chk("post_rst_no_stale", 32'(got_q.size()), 32'd0);
    send(4'd0, 8'h80, 8'hFF);
    idle();
    drain();
    chk("post_rst_n", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("post_rst_rsp", 32'(got_q[0]), 32'h80);
    chk("post_rst_issued_end", 32'(bus.o_issued_cnt), 32'd1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
